// File: rtl/multi_debouncer.sv
// Multi-channel button debouncer: sync, tick-sampled stability count, press/release pulses, optional DEB_REPEAT_EN auto-repeat.
// Latency: level/pulses follow a stable input change within 2 + STABLE*2^DIV_W sysclk cycles.
// Backpressure: none; inputs are free-running levels and outputs are one-cycle pulses.
module multi_debouncer #(
    parameter int CHANNELS     = 4,
    parameter int DIV_W        = 21,
    parameter int STABLE       = 3,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                sysclk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] btn,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] released,
    output logic                tick
);

    // One width covers both the change and repeat counters at their largest terminal count.
    localparam int CNT_MAX_SR = (STABLE > REPEAT_RATE) ? STABLE : REPEAT_RATE;
    localparam int CNT_MAX    = (CNT_MAX_SR > REPEAT_DELAY) ? CNT_MAX_SR : REPEAT_DELAY;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [DIV_W-1:0]    div_cnt;
    logic [CNT_W-1:0]    chg_cnt [CHANNELS];
    logic                tick_now;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] rep_fire;

    assign tick_now = &div_cnt;
    assign tick     = tick_now;

    always_comb begin
        accept = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            accept[i] = tick_now && (sync2[i] != level[i]) &&
                        ((chg_cnt[i] + CNT_ONE) == STABLE_C);
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            div_cnt  <= '0;
            level    <= '0;
            press    <= '0;
            released <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                chg_cnt[i] <= '0;
            end
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            div_cnt <= div_cnt + DIV_ONE;
            for (int i = 0; i < CHANNELS; i++) begin
                if (tick_now) begin
                    // A matching sample, or an accepted change, restarts the stability run.
                    if ((sync2[i] == level[i]) || accept[i]) begin
                        chg_cnt[i] <= '0;
                    end else begin
                        chg_cnt[i] <= chg_cnt[i] + CNT_ONE;
                    end
                end
            end
            level    <= level ^ accept;
            press    <= (accept & ~level) | rep_fire;
            released <= accept & level;
        end
    end

`ifdef DEB_REPEAT_EN
    localparam logic [CNT_W-1:0] DELAY_C = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_C  = CNT_W'(REPEAT_RATE);

    logic [CNT_W-1:0]    rep_cnt [CHANNELS];
    logic [CHANNELS-1:0] rep_phase;

    // rep_phase clear: waiting out the initial delay; set: free-running at the repeat rate.
    always_comb begin
        rep_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rep_fire[i] = tick_now && level[i] && !accept[i] &&
                          ((rep_cnt[i] + CNT_ONE) == (rep_phase[i] ? RATE_C : DELAY_C));
        end
    end

    always_ff @(posedge sysclk) begin
        if (rst) begin
            rep_phase <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rep_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!level[i] || accept[i]) begin
                    rep_cnt[i]   <= '0;
                    rep_phase[i] <= 1'b0;
                end else if (tick_now) begin
                    if (rep_fire[i]) begin
                        rep_cnt[i]   <= '0;
                        rep_phase[i] <= 1'b1;
                    end else begin
                        rep_cnt[i] <= rep_cnt[i] + CNT_ONE;
                    end
                end
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: per-cycle comparison against a tick-level behavioural model plus directed literal checks.
`timescale 1ns/1ps
module tb_multi_debouncer;
    localparam int CH     = 4;
    localparam int DIV_W  = 4;
    localparam int PERIOD = 1 << DIV_W;
    localparam int STABLE = 3;
    localparam int RDELAY = 4;
    localparam int RRATE  = 2;
`ifdef DEB_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    logic          sysclk = 1'b0;
    logic          rst;
    logic [CH-1:0] btn;
    logic [CH-1:0] level;
    logic [CH-1:0] press;
    logic [CH-1:0] released;
    logic          tick;

    int checks = 0;
    int errors = 0;

    multi_debouncer #(
        .CHANNELS(CH), .DIV_W(DIV_W), .STABLE(STABLE),
        .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)
    ) dut (
        .sysclk(sysclk), .rst(rst), .btn(btn), .level(level),
        .press(press), .released(released), .tick(tick)
    );

    always #5 sysclk = ~sysclk;

    // Model state: n = cycles since reset, d1/d2 = input delayed by one/two edges.
    int            n;
    logic [CH-1:0] d1, d2, m_level, m_press, m_rel;
    int            run   [CH];
    int            since [CH];

    int obs_press [CH];
    int obs_rel   [CH];
    int obs_all_press = 0;
    int obs_all_rel   = 0;

    task automatic model_step();
        logic was_tick;
        if (rst) begin
            n = 0; d1 = '0; d2 = '0;
            m_level = '0; m_press = '0; m_rel = '0;
            for (int c = 0; c < CH; c++) begin
                run[c] = 0; since[c] = 0;
            end
        end else begin
            was_tick = (n % PERIOD) == (PERIOD - 1);
            m_press = '0;
            m_rel   = '0;
            if (was_tick) begin
                for (int c = 0; c < CH; c++) begin
                    if (d2[c] != m_level[c]) run[c] = run[c] + 1;
                    else run[c] = 0;
                    if (run[c] == STABLE) begin
                        run[c] = 0;
                        if (m_level[c]) m_rel[c] = 1'b1;
                        else begin
                            m_press[c] = 1'b1;
                            since[c]   = 0;
                        end
                        m_level[c] = ~m_level[c];
                    end else if (m_level[c]) begin
                        since[c] = since[c] + 1;
                        if (REP && (since[c] == RDELAY ||
                            (since[c] > RDELAY && ((since[c] - RDELAY) % RRATE) == 0)))
                            m_press[c] = 1'b1;
                    end
                end
            end
            d2 = d1;
            d1 = btn;
            n  = n + 1;
        end
    endtask

    task automatic chk(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s got=%b required=%b t=%0t", name, got, exp, $time);
        end
    endtask

    initial begin
        for (int c = 0; c < CH; c++) begin
            obs_press[c] = 0;
            obs_rel[c]   = 0;
        end
        @(posedge sysclk);
        forever begin
            @(negedge sysclk);
            model_step();
            chk("level", level, m_level);
            chk("press", press, m_press);
            chk("release", released, m_rel);
            chk("tick", {{(CH-1){1'b0}}, tick},
                {{(CH-1){1'b0}}, (!rst && (n % PERIOD) == (PERIOD - 1))});
            for (int c = 0; c < CH; c++) begin
                obs_press[c] += int'(press[c]);
                obs_rel[c]   += int'(released[c]);
            end
            if (press == '1) obs_all_press++;
            if (released == '1) obs_all_rel++;
        end
    end

    task automatic step();
        @(negedge sysclk);
        #2;
    endtask

    task automatic lit(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic wait_level(input string name, input int ch, input logic val,
                              input int budget, output int k);
        k = 0;
        while (level[ch] !== val && k < budget) begin
            step();
            k++;
        end
        if (level[ch] !== val) begin
            checks++;
            errors++;
            $display("FAIL %s timeout after %0d cycles level=%b required=%b", name, k, level[ch], val);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int bp;
        int br;
        rst = 1'b1;
        btn = '0;
        repeat (3) step();
        lit("reset_level", int'(level), 0);
        lit("reset_press", int'(press), 0);
        lit("reset_release", int'(released), 0);
        lit("reset_tick", int'(tick), 0);

        // Prescaler: first strobe 15 cycles after reset release.
        rst = 1'b0;
        k = 0;
        while (!tick && k < 40) begin
            step();
            k++;
        end
        lit("first_tick_cycle", k, 15);

        // Single clean rise on channel 0.
        bp = obs_press[0];
        br = obs_rel[0];
        btn[0] = 1'b1;
        wait_level("rise0", 0, 1'b1, 200, k);
        lit("rise0_latency_35_to_50", int'(k >= 35 && k <= 50), 1);
        repeat (2 * PERIOD) step();
        lit("rise0_press_count", obs_press[0] - bp, 1);
        lit("rise0_release_count", obs_rel[0] - br, 0);
        lit("rise0_level", int'(level[0]), 1);

        // Two-tick glitch on channel 1 must be rejected.
        bp = obs_press[1];
        br = obs_rel[1];
        btn[1] = 1'b1;
        repeat (2 * PERIOD) step();
        btn[1] = 1'b0;
        repeat (5 * PERIOD) step();
        lit("glitch1_level", int'(level[1]), 0);
        lit("glitch1_press_count", obs_press[1] - bp, 0);
        lit("glitch1_release_count", obs_rel[1] - br, 0);

        // All channels together.
        btn = '0;
        repeat (5 * PERIOD) step();
        lit("all_low_level", int'(level), 0);
        bp = obs_all_press;
        btn = '1;
        repeat (5 * PERIOD) step();
        lit("all_press_cycles", obs_all_press - bp, 1);
        lit("all_high_level", int'(level), 15);
        br = obs_all_rel;
        btn = '0;
        repeat (5 * PERIOD) step();
        lit("all_release_cycles", obs_all_rel - br, 1);
        lit("all_low_again_level", int'(level), 0);

        // Reset one tick into a stable high on channel 2.
        btn = 4'b0100;
        repeat (PERIOD) step();
        rst = 1'b1;
        step();
        lit("midreset_level", int'(level), 0);
        lit("midreset_press", int'(press), 0);
        lit("midreset_release", int'(released), 0);
        lit("midreset_tick", int'(tick), 0);
        rst = 1'b0;
        wait_level("rise2_after_reset", 2, 1'b1, 100, k);
        lit("rise2_after_reset_cycles", k, 48);

        // Long hold on channel 3: auto-repeat when built in, single press otherwise.
        bp = obs_press[3];
        btn[3] = 1'b1;
        wait_level("rise3", 3, 1'b1, 200, k);
        repeat (12 * PERIOD) step();
        lit("hold3_press_count", obs_press[3] - bp, REP ? 6 : 1);
        br = obs_rel[3];
        btn[3] = 1'b0;
        wait_level("fall3", 3, 1'b0, 200, k);
        bp = obs_press[3];
        repeat (4 * PERIOD) step();
        lit("after_fall3_press_count", obs_press[3] - bp, 0);
        lit("fall3_release_count", obs_rel[3] - br, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
